alu_logic_arbiter: RTL and testbench

Shares one 16-bit bitwise logic unit (AND/OR/XOR/NAND/NOR/XNOR/NOT/PASS) between two requesters, using round-robin arbitration and valid/ready handshakes on both the request and response sides. It sits between the ALU front-end issue ports and the gate-level logic datapath. It sequences each operation through capture, execute and respond phases, and returns the result tagged with the requester ID.

---
 rtl/alu_logic_arbiter.sv | 103 ++++++++++
 tb/tb_alu_logic_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_logic_arbiter.sv
// rtl/alu_logic_arbiter.sv - two-requester round-robin arbiter around a shared 16-bit bitwise logic unit
module alu_logic_arbiter #(
   parameter int size = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [2:0]      req0_op,
   input  logic [size-1:0] req0_a,
   input  logic [size-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [2:0]      req1_op,
   input  logic [size-1:0] req1_a,
   input  logic [size-1:0] req1_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic            rsp_id,
   output logic [size-1:0] rsp_data,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state;
   logic              pri;
   logic [2:0]        cap_op;
   logic [size-1:0]   cap_a;
   logic [size-1:0]   cap_b;
   logic              cap_id;
   logic              any_valid;
   logic              grant_id;
   logic [size-1:0]   result;

   assign any_valid = req0_valid | req1_valid;
   // pri only breaks ties; a lone requester always wins
   assign grant_id  = (req0_valid & req1_valid) ? pri : req1_valid;

   // Readies are gated by rst_n so nothing is accepted while reset is held
   assign req0_ready = rst_n & (state == IDLE) & any_valid & ~grant_id;
   assign req1_ready = rst_n & (state == IDLE) & any_valid &  grant_id;
   assign busy       = (state != IDLE);

   always_comb begin
      result = '0;
      case (cap_op)
         3'b000:  result = cap_a & cap_b;
         3'b001:  result = cap_a | cap_b;
         3'b010:  result = cap_a ^ cap_b;
         3'b011:  result = ~(cap_a & cap_b);
         3'b100:  result = ~(cap_a | cap_b);
         3'b101:  result = ~(cap_a ^ cap_b);
         3'b110:  result = ~cap_a;
         default: result = cap_a;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         pri       <= 1'b0;
         cap_op    <= '0;
         cap_a     <= '0;
         cap_b     <= '0;
         cap_id    <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  cap_op <= grant_id ? req1_op : req0_op;
                  cap_a  <= grant_id ? req1_a  : req0_a;
                  cap_b  <= grant_id ? req1_b  : req0_b;
                  cap_id <= grant_id;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               rsp_data  <= result;
               rsp_id    <= cap_id;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  pri       <= ~rsp_id;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// tb/tb_alu_logic_arbiter.sv - directed and randomized checks of alu_logic_arbiter against a transaction model
module tb_alu_logic_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, busy;
   logic [15:0] rsp_data;

   always #5 clk = ~clk;

   alu_logic_arbiter #(.size(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .busy(busy)
   );

   typedef struct {
      logic        id;
      logic [15:0] data;
   } rsp_t;

   int          checks = 0;
   int          failures = 0;
   rsp_t        exp_q[$];
   bit          outstanding = 0;
   int          age = 0;
   bit          pref = 0;
   bit          prev_rst_low = 0;
   int          accepts = 0;
   logic [15:0] last_data = '0;
   logic        last_id = 1'b0;

   function automatic logic [15:0] ref_op(logic [2:0] op, logic [15:0] a, logic [15:0] b);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample mid-cycle, compare with the transaction model, advance past the edge
   task automatic cyc();
      bit   g0, g1;
      rsp_t r;
      @(negedge clk);
      if (!rst_n) begin
         check("rst_ready0", {31'd0, req0_ready}, 0);
         check("rst_ready1", {31'd0, req1_ready}, 0);
         if (prev_rst_low) begin
            check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
            check("rst_rsp_data", {16'd0, rsp_data}, 0);
            check("rst_rsp_id", {31'd0, rsp_id}, 0);
            check("rst_busy", {31'd0, busy}, 0);
         end
         outstanding  = 0;
         exp_q.delete();
         pref         = 0;
         prev_rst_low = 1;
      end else begin
         prev_rst_low = 0;
         if (outstanding) begin
            age++;
            check("ready0_while_busy", {31'd0, req0_ready}, 0);
            check("ready1_while_busy", {31'd0, req1_ready}, 0);
            check("busy_in_flight", {31'd0, busy}, 1);
            check("rsp_valid_latency", {31'd0, rsp_valid}, (age >= 2) ? 1 : 0);
            if (age >= 2 && exp_q.size() > 0) begin
               check("rsp_data", {16'd0, rsp_data}, {16'd0, exp_q[0].data});
               check("rsp_id", {31'd0, rsp_id}, {31'd0, exp_q[0].id});
               if (rsp_ready) begin
                  last_data   = exp_q[0].data;
                  last_id     = exp_q[0].id;
                  pref        = ~exp_q[0].id;
                  void'(exp_q.pop_front());
                  outstanding = 0;
                  accepts++;
               end
            end
         end else begin
            g0 = req0_valid && (!req1_valid || pref == 0);
            g1 = req1_valid && (!req0_valid || pref == 1);
            check("grant0", {31'd0, req0_ready}, {31'd0, g0});
            check("grant1", {31'd0, req1_ready}, {31'd0, g1});
            check("busy_idle", {31'd0, busy}, 0);
            check("rsp_valid_idle", {31'd0, rsp_valid}, 0);
            if (g0 || g1) begin
               r.id   = g1;
               r.data = g1 ? ref_op(req1_op, req1_a, req1_b) : ref_op(req0_op, req0_a, req0_b);
               exp_q.push_back(r);
               outstanding = 1;
               age = 0;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_accepts(int target);
      int k = 0;
      while (accepts < target && k < 20) begin
         cyc();
         k++;
      end
      check("accept_wait", accepts, target);
   endtask

   initial begin
      int base;
      rst_n = 1'b0; rsp_ready = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h1111; req0_b = 16'h2222;
      req1_valid = 1'b1; req1_op = 3'd1; req1_a = 16'h3333; req1_b = 16'h4444;
      #1;
      repeat (3) cyc();

      // XNOR from requester 0
      rst_n = 1'b1; req1_valid = 1'b0;
      req0_op = 3'd5; req0_a = 16'h00F8; req0_b = 16'h0147;
      cyc();
      req0_valid = 1'b0;
      wait_accepts(1);
      check("xnor_data", {16'd0, last_data}, 32'hFE40);
      check("xnor_id", {31'd0, last_id}, 0);

      // Contention straight out of reset
      rst_n = 1'b0;
      repeat (2) cyc();
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd0; req0_a = 16'h00F8; req0_b = 16'h0147;
      req1_valid = 1'b1; req1_op = 3'd2; req1_a = 16'h00F8; req1_b = 16'h0147;
      base = accepts;
      wait_accepts(base + 1);
      check("cont1_id", {31'd0, last_id}, 0);
      check("cont1_data", {16'd0, last_data}, 32'h0040);
      wait_accepts(base + 2);
      check("cont2_id", {31'd0, last_id}, 1);
      check("cont2_data", {16'd0, last_data}, 32'h01BF);
      wait_accepts(base + 3);
      check("cont3_id", {31'd0, last_id}, 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Back-pressure on a NOT from requester 1
      rsp_ready = 1'b0;
      req1_valid = 1'b1; req1_op = 3'd6; req1_a = 16'h1234; req1_b = 16'hFFFF;
      cyc();
      req1_valid = 1'b0;
      repeat (2) cyc();
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {31'd0, rsp_valid}, 1);
         check("bp_data", {16'd0, rsp_data}, 32'hEDCB);
         cyc();
      end
      rsp_ready = 1'b1;
      base = accepts;
      wait_accepts(base + 1);
      check("bp_done_data", {16'd0, last_data}, 32'hEDCB);

      // Operand isolation after a PASS handshake
      req0_valid = 1'b1; req0_op = 3'd7; req0_a = 16'hAAAA; req0_b = 16'h0000;
      cyc();
      req0_valid = 1'b0; req0_a = 16'h5555;
      base = accepts;
      wait_accepts(base + 1);
      check("iso_data", {16'd0, last_data}, 32'hAAAA);

      // Reset while the operation is in EXEC
      req0_valid = 1'b1; req0_op = 3'd3; req0_a = 16'hF0F0; req0_b = 16'hFF00;
      cyc();
      req0_valid = 1'b0; rst_n = 1'b0;
      repeat (2) cyc();
      check("midrst_no_rsp", {31'd0, rsp_valid}, 0);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_op = 3'd5; req0_a = 16'h00F8; req0_b = 16'h0147;
      req1_valid = 1'b1; req1_op = 3'd0;
      base = accepts;
      cyc();
      req0_valid = 1'b0; req1_valid = 1'b0;
      wait_accepts(base + 1);
      check("midrst_id", {31'd0, last_id}, 0);
      check("midrst_data", {16'd0, last_data}, 32'hFE40);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_op = 3'($urandom); req0_a = 16'($urandom); req0_b = 16'($urandom);
         req1_op = 3'($urandom); req1_a = 16'($urandom); req1_b = 16'($urandom);
         rsp_ready = ($urandom_range(0, 2) != 0);
         cyc();
      end
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
      repeat (5) cyc();
      check("drain_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
